// File: rtl/banda_pkg.sv
// Shared types and constants for the banda assembly-line sequencer.
// Operand word layout is {a,b,c,d,e}; the datapath computes f = ((a&b)|b) & ~(d&e).
package banda_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned WORD_W        = 5;

  localparam int unsigned A_BIT = 4;
  localparam int unsigned B_BIT = 3;
  localparam int unsigned C_BIT = 2;
  localparam int unsigned D_BIT = 1;
  localparam int unsigned E_BIT = 0;

endpackage

// File: rtl/banda_valid_chain.sv
// Per-stage occupancy tracker: a DEPTH-bit valid shift register that moves in
// lock-step with the shared datapath load, plus a population count.
module banda_valid_chain
  import banda_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           clear_n,
  input  logic                           clr,
  input  logic                           advance,
  input  logic                           insert,
  output logic [DEPTH-1:0]               v,
  output logic [DEPTH-1:0]               v_next,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] pop;

  always_comb begin
    v_next = v;
    if (clr) begin
      v_next = '0;
    end else if (advance) begin
      v_next = {v[DEPTH-2:0], insert};
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      v <= '0;
    end else begin
      v <= v_next;
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pop = pop + OCC_W'(v[i]);
    end
    occupancy = pop;
  end

endmodule

// File: rtl/banda_ctrl.sv
// Sequencer for the 4-stage assembly-line datapath: input/output handshakes,
// shared load/clear generation, drain/flush control and debug counters.
module banda_ctrl
  import banda_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       clear_n,
  input  logic                       in_valid,
  input  logic [WORD_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic                       out_f,
  input  logic                       out_ready,
  input  logic                       drain,
  input  logic                       flush,
  output logic                       drain_done,
  output logic [WORD_W-1:0]          pipe_din,
  output logic                       pipe_load,
  output logic                       pipe_clear,
  input  logic                       pipe_f,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           acc_cnt,
  output logic [CNT_W-1:0]           dlv_cnt
);

  state_t           state;
  state_t           state_nxt;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic             run_ok;
  logic             advance;
  logic             accept;
  logic             deliver;
  logic             done_nxt;

  // A flush request (or reset) freezes the pipe in the same cycle so that no
  // handshake completes; the FLUSH state itself then clears everything.
  always_comb begin
    run_ok     = clear_n & ~flush & (state != FLUSH);
    advance    = run_ok & (~v[DEPTH-1] | out_ready);
    in_ready   = advance & ((state == IDLE) | (state == RUN));
    out_valid  = run_ok & v[DEPTH-1];
    accept     = in_valid & in_ready;
    deliver    = out_valid & out_ready;
    pipe_load  = advance;
    pipe_clear = ~clear_n | (state == FLUSH);
    pipe_din   = in_data;
    out_f      = pipe_f;
  end

  banda_valid_chain #(
    .DEPTH (DEPTH)
  ) u_chain (
    .clk       (clk),
    .clear_n   (clear_n),
    .clr       (state == FLUSH),
    .advance   (advance),
    .insert    (accept),
    .v         (v),
    .v_next    (v_nxt),
    .occupancy (occupancy)
  );

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (flush) begin
      state_nxt = FLUSH;
    end else begin
      unique case (state)
        IDLE: begin
          if (drain)       state_nxt = DRAIN;
          else if (accept) state_nxt = RUN;
        end
        RUN: begin
          if (drain)             state_nxt = DRAIN;
          else if (v_nxt == '0)  state_nxt = IDLE;
        end
        DRAIN: begin
          if (v == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        FLUSH:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state      <= IDLE;
      drain_done <= 1'b0;
      acc_cnt    <= '0;
      dlv_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      drain_done <= done_nxt;
      acc_cnt    <= acc_cnt + CNT_W'(accept);
      dlv_cnt    <= dlv_cnt + CNT_W'(deliver);
    end
  end

endmodule

// File: tb/tb_banda_ctrl.sv
// Self-checking bench for banda_ctrl with a behavioural datapath fixture and a
// queue-based reference model for randomized streaming.
module tb_banda_ctrl;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        in_valid;
  logic [4:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_f;
  logic        out_ready;
  logic        drain;
  logic        flush;
  logic        drain_done;
  logic [4:0]  pipe_din;
  logic        pipe_load;
  logic        pipe_clear;
  logic        pipe_f;
  logic [2:0]  occupancy;
  logic [15:0] acc_cnt;
  logic [15:0] dlv_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  banda_ctrl #(
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_f      (out_f),
    .out_ready  (out_ready),
    .drain      (drain),
    .flush      (flush),
    .drain_done (drain_done),
    .pipe_din   (pipe_din),
    .pipe_load  (pipe_load),
    .pipe_clear (pipe_clear),
    .pipe_f     (pipe_f),
    .occupancy  (occupancy),
    .acc_cnt    (acc_cnt),
    .dlv_cnt    (dlv_cnt)
  );

  function automatic logic fref(input logic [4:0] w);
    logic a, b, d, e;
    a = w[4]; b = w[3]; d = w[1]; e = w[0];
    return ((a & b) | b) & ~(d & e);
  endfunction

  // External datapath fixture: four registers on the shared load/clear.
  logic [4:0] dp [4];
  always @(posedge clk) begin
    if (pipe_clear) begin
      for (int i = 0; i < 4; i++) dp[i] <= '0;
    end else if (pipe_load) begin
      dp[3] <= dp[2];
      dp[2] <= dp[1];
      dp[1] <= dp[0];
      dp[0] <= pipe_din;
    end
  end
  assign pipe_f = fref(dp[3]);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    clear_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    drain = 1'b0; flush = 1'b0;
    tick();
    clear_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_n = 1'b0; in_valid = 1'b1; in_data = 5'b11000; out_ready = 1'b1;
    drain = 1'b0; flush = 1'b0;
    tick();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (pipe_load !== 1'b0) begin errors++; $display("FAIL reset_pipe_load got=%0b exp=0", pipe_load); end
    checks++; if (pipe_clear !== 1'b1) begin errors++; $display("FAIL reset_pipe_clear got=%0b exp=1", pipe_clear); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (acc_cnt !== 16'd0 || dlv_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", acc_cnt, dlv_cnt); end
    checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL reset_drain_done got=%0b exp=0", drain_done); end
    in_valid = 1'b0; out_ready = 1'b0;
    clear_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (pipe_clear !== 1'b0) begin errors++; $display("FAIL post_reset_pipe_clear got=%0b exp=0", pipe_clear); end
    tick();
  endtask

  task automatic test_streaming();
    logic [4:0] w [4];
    logic       f_exp [4];
    w = '{5'b11000, 5'b11011, 5'b00011, 5'b01000};
    f_exp = '{1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got=%0b exp=1", i, in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid[%0d] got=%0b exp=0", i, out_valid); end
      tick();
    end
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_out_valid[%0d] got=%0b exp=1", j, out_valid); end
      checks++; if (out_f !== f_exp[j]) begin errors++; $display("FAIL stream_out_f[%0d] got=%0b exp=%0b", j, out_f, f_exp[j]); end
      tick();
    end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_tail_valid got=%0b exp=0", out_valid); end
    checks++; if (acc_cnt !== 16'd4) begin errors++; $display("FAIL stream_acc_cnt got=%0d exp=4", acc_cnt); end
    checks++; if (dlv_cnt !== 16'd4) begin errors++; $display("FAIL stream_dlv_cnt got=%0d exp=4", dlv_cnt); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL stream_occupancy got=%0d exp=0", occupancy); end
  endtask

  task automatic test_backpressure();
    logic [4:0] w [4];
    w[0] = 5'b01000 | (5'($urandom) & 5'b10100);
    for (int i = 1; i < 4; i++) w[i] = 5'($urandom);
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      tick();
    end
    in_data = 5'b11111;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_occupancy[%0d] got=%0d exp=4", c, occupancy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%0b exp=0", c, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_f !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got=%0b/%0b exp=1/1", c, out_valid, out_f); end
      tick();
    end
    checks++; if (acc_cnt !== 16'd4) begin errors++; $display("FAIL bp_acc_cnt got=%0d exp=4", acc_cnt); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_f !== fref(w[j])) begin errors++; $display("FAIL bp_release[%0d] got=%0b/%0b exp=1/%0b", j, out_valid, out_f, fref(w[j])); end
      tick();
    end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%0b exp=0", out_valid); end
    checks++; if (dlv_cnt !== 16'd4) begin errors++; $display("FAIL bp_dlv_cnt got=%0d exp=4", dlv_cnt); end
  endtask

  task automatic test_flush();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 5'($urandom);
      tick();
    end
    #1;
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL flush_pre_occ got=%0d exp=3", occupancy); end
    flush = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_accept_suppressed got=%0b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (pipe_clear !== 1'b1 || pipe_load !== 1'b0) begin errors++; $display("FAIL flush_lines got=%0b/%0b exp=1/0", pipe_clear, pipe_load); end
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_handshake got=%0b/%0b exp=0/0", in_ready, out_valid); end
    tick();
    #1;
    checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got=%0d/%0b exp=0/0", occupancy, out_valid); end
    checks++; if (pipe_clear !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle got=%0b/%0b exp=0/1", pipe_clear, in_ready); end
    checks++; if (acc_cnt !== 16'd3 || dlv_cnt !== 16'd0) begin errors++; $display("FAIL flush_counters got=%0d/%0d exp=3/0", acc_cnt, dlv_cnt); end
  endtask

  task automatic test_drain();
    logic [4:0] w [2];
    int dl = 0;
    bit seen = 1'b0;
    w[0] = 5'b01000; w[1] = 5'b01011;
    apply_reset();
    drain = 1'b1;
    tick();
    drain = 1'b0;
    #1;
    checks++; if (drain_done !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL drain_idle_wait got=%0b/%0b exp=0/0", drain_done, in_ready); end
    tick();
    #1;
    checks++; if (drain_done !== 1'b1) begin errors++; $display("FAIL drain_idle_done got=%0b exp=1", drain_done); end
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = w[i];
      tick();
    end
    in_valid = 1'b0; drain = 1'b1;
    tick();
    drain = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      #1;
      if (drain_done) begin
        seen = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready_back got=%0b exp=1", in_ready); end
      end else begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready[%0d] got=%0b exp=0", c, in_ready); end
        if (out_valid && out_ready) begin
          if (dl < 2) begin
            checks++; if (out_f !== fref(w[dl])) begin errors++; $display("FAIL drain_out_f[%0d] got=%0b exp=%0b", dl, out_f, fref(w[dl])); end
          end
          dl++;
        end
      end
      tick();
    end
    #1;
    checks++; if (!seen) begin errors++; $display("FAIL drain_done_timeout got=0 exp=1"); end
    checks++; if (dl !== 2) begin errors++; $display("FAIL drain_deliveries got=%0d exp=2", dl); end
    checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL drain_done_pulse got=%0b exp=0", drain_done); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 5'($urandom);
      tick();
    end
    in_valid = 1'b0; flush = 1'b1; drain = 1'b1;
    tick();
    flush = 1'b0; drain = 1'b0;
    #1;
    checks++; if (pipe_clear !== 1'b1) begin errors++; $display("FAIL simul_flush_wins got=%0b exp=1", pipe_clear); end
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (drain_done !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL simul_no_drain[%0d] got=%0b/%0b exp=0/1", c, drain_done, in_ready); end
      tick();
    end
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 5'($urandom);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_data = 5'($urandom);
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL simul_both[%0d] got=%0b/%0b exp=1/1", k, in_ready, out_valid); end
      tick();
      #1;
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL simul_occ[%0d] got=%0d exp=4", k, occupancy); end
      checks++; if (acc_cnt !== 16'(4 + k) || dlv_cnt !== 16'(k)) begin errors++; $display("FAIL simul_cnt[%0d] got=%0d/%0d exp=%0d/%0d", k, acc_cnt, dlv_cnt, 4 + k, k); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [4:0] w;
    int lat;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 5'($urandom);
      tick();
    end
    in_valid = 1'b0; clear_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || pipe_load !== 1'b0 || pipe_clear !== 1'b1) begin errors++; $display("FAIL mid_reset_lines got=%0b%0b%0b%0b exp=0001", in_ready, out_valid, pipe_load, pipe_clear); end
    tick();
    clear_n = 1'b1;
    #1;
    checks++; if (occupancy !== 3'd0 || acc_cnt !== 16'd0 || dlv_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_state got=%0d/%0d/%0d exp=0/0/0", occupancy, acc_cnt, dlv_cnt); end
    w = 5'b01000 | (5'($urandom) & 5'b10101);
    in_valid = 1'b1; in_data = w; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    for (lat = 0; lat < 10; lat++) begin
      if (out_valid) break;
      tick();
      #1;
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL mid_reset_latency got=%0d exp=3", lat); end
    checks++; if (out_f !== fref(w)) begin errors++; $display("FAIL mid_reset_out_f got=%0b exp=%0b", out_f, fref(w)); end
    tick();
  endtask

  typedef struct {
    logic [4:0] data;
    int         stage;
  } slot_t;

  task automatic test_random();
    slot_t q[$];
    int    m_acc = 0;
    int    m_dlv = 0;
    bit    e_valid, e_ready;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 5'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      e_valid = (q.size() > 0) && (q[0].stage == 3);
      e_ready = !e_valid || out_ready;
      checks++; if (in_ready !== e_ready) begin errors++; $display("FAIL rnd_in_ready[%0d] got=%0b exp=%0b", c, in_ready, e_ready); end
      checks++; if (out_valid !== e_valid) begin errors++; $display("FAIL rnd_out_valid[%0d] got=%0b exp=%0b", c, out_valid, e_valid); end
      checks++; if (occupancy !== 3'(q.size())) begin errors++; $display("FAIL rnd_occupancy[%0d] got=%0d exp=%0d", c, occupancy, q.size()); end
      checks++; if (acc_cnt !== 16'(m_acc) || dlv_cnt !== 16'(m_dlv)) begin errors++; $display("FAIL rnd_counters[%0d] got=%0d/%0d exp=%0d/%0d", c, acc_cnt, dlv_cnt, m_acc, m_dlv); end
      if (e_valid) begin
        checks++; if (out_f !== fref(q[0].data)) begin errors++; $display("FAIL rnd_out_f[%0d] got=%0b exp=%0b", c, out_f, fref(q[0].data)); end
      end
      if (e_ready) begin
        if (e_valid) begin
          void'(q.pop_front());
          m_dlv++;
        end
        foreach (q[i]) q[i].stage++;
        if (in_valid) begin
          q.push_back('{data: in_data, stage: 0});
          m_acc++;
        end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_drain();
    test_simultaneous();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
